// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
//   RESET_PC     : address of the first fetched instruction
//   IF_ID_BUS_W  : width of the IF->ID payload {inst, pc}
//   if_state_e   : fetch-stage state encoding
package cpu_pkg;
  localparam logic [31:0] RESET_PC    = 32'h1c000000;
  localparam int          IF_ID_BUS_W = 64;

  typedef enum logic [1:0] {
    BOOT = 2'd0,  // nothing in flight
    WAIT = 2'd1,  // SRAM read data this cycle belongs to fs_pc
    HOLD = 2'd2   // instruction for fs_pc parked in the hold buffer
  } if_state_e;
endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction hold buffer with bypass mux.
//   clk, reset : clock, async active-low reset
//   capture    : park rdata (ID stalled on a fresh fetch)
//   clear      : drop buffered entry (new fetch issued); wins over capture
//   live       : IF holds a valid instruction; gates raw SRAM data
//   rdata      : SRAM read data
//   buf_valid  : buffer holds the instruction
//   inst       : instruction presented to ID
module if_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic        live,
  input  logic [31:0] rdata,
  output logic        buf_valid,
  output logic [31:0] inst
);
  logic [31:0] buf_inst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_inst  <= rdata;
    end
  end

  // Zero when IF is empty so stale SRAM data (e.g. after a mid-run reset)
  // never leaks onto the bus.
  assign inst = buf_valid ? buf_inst : (live ? rdata : 32'h0);
endmodule

// File: rtl/stage_1_if.sv
// Instruction-fetch stage: PC generation, SRAM request, IF->ID handshake.
//   clk, reset        : clock, async active-low reset
//   valid_1, allow_2  : IF->ID valid / ID accept
//   stage_1_to_2      : {inst, pc}
//   br_taken/br_target: redirect from ID
//   inst_sram_*       : synchronous instruction SRAM port (1-cycle read)
module stage_1_if
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  output logic                   valid_1,
  input  logic                   allow_2,
  output logic [IF_ID_BUS_W-1:0] stage_1_to_2,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  output logic                   inst_sram_en,
  output logic [31:0]            inst_sram_addr,
  input  logic [31:0]            inst_sram_rdata
);
  logic [31:0] fs_pc;
  logic        fs_valid;
  if_state_e   state;

  logic        fs_allowin;
  logic        req;
  logic        capture;
  logic        buf_valid;
  logic [31:0] nextpc;
  logic [31:0] inst;

  assign fs_allowin = !fs_valid || allow_2 || br_taken;
  assign nextpc     = br_taken ? br_target : fs_pc + 32'd4;
  assign req        = reset && fs_allowin;
  // In WAIT with no request the only cause is an ID stall: park the data.
  assign capture    = (state == WAIT) && !req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_pc    <= RESET_PC - 32'd4;
      fs_valid <= 1'b0;
      state    <= BOOT;
    end else if (req) begin
      fs_pc    <= nextpc;
      fs_valid <= 1'b1;
      state    <= WAIT;
    end else if (capture) begin
      state    <= HOLD;
    end
  end

  if_hold_buf u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .clear     (req),
    .live      (fs_valid),
    .rdata     (inst_sram_rdata),
    .buf_valid (buf_valid),
    .inst      (inst)
  );

  // No delay slot: the instruction in IF is squashed by a taken branch.
  assign valid_1        = fs_valid && !br_taken;
  assign stage_1_to_2   = {inst, fs_pc};
  assign inst_sram_en   = req;
  assign inst_sram_addr = nextpc;
endmodule
